// File: rtl/injection_module_sync.sv
// Fault-injection wrapper around y = (a & b) | (e & f).
// A faulty copy of the function can have one net forced (stuck-at-0,
// stuck-at-1 or bit-flip). A fault-free golden copy runs alongside it.
// Both results are registered, compared, and mismatching cycles are counted
// in a saturating counter.
module injection_module_sync #(
  parameter int CNT_W   = 16,
  parameter bit SYNC_IN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             e,
  input  logic             f,
  input  logic             inj_en,
  input  logic [2:0]       inj_sel,
  input  logic [1:0]       inj_mode,
  input  logic             cnt_clr,
  output logic             y,
  output logic             y_golden,
  output logic             mismatch,
  output logic             fault_active,
  output logic [CNT_W-1:0] mismatch_cnt
);

  // Net indices used by inj_sel.
  localparam logic [2:0] SEL_A    = 3'd0;
  localparam logic [2:0] SEL_B    = 3'd1;
  localparam logic [2:0] SEL_E    = 3'd2;
  localparam logic [2:0] SEL_F    = 3'd3;
  localparam logic [2:0] SEL_N1   = 3'd4;
  localparam logic [2:0] SEL_N2   = 3'd5;
  localparam logic [2:0] SEL_Y    = 3'd6;
  localparam logic [2:0] SEL_NONE = 3'd7;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Fault operator: 1 = stuck-at-0, 2 = stuck-at-1, 3 = invert, 0 = pass.
  function automatic logic fault_op(input logic x, input logic [1:0] mode);
    logic res;
    case (mode)
      2'd1:    res = 1'b0;
      2'd2:    res = 1'b1;
      2'd3:    res = ~x;
      default: res = x;
    endcase
    return res;
  endfunction

  // Applies the fault operator only on the net currently targeted.
  function automatic logic net_op(input logic x, input logic apply,
                                  input logic [2:0] sel, input logic [2:0] net,
                                  input logic [1:0] mode);
    logic res;
    if (apply && (sel == net)) begin
      res = fault_op(x, mode);
    end else begin
      res = x;
    end
    return res;
  endfunction

  logic w_ra, w_rb, w_re, w_rf;
  logic w_apply;
  logic w_fa, w_fb, w_fe, w_ff;
  logic w_fn1, w_fn2, w_fy;
  logic w_gy;

  generate
    if (SYNC_IN) begin : g_sync_in
      logic r_a, r_b, r_e, r_f;

      // Capture the function inputs once per clock.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a <= 1'b0;
          r_b <= 1'b0;
          r_e <= 1'b0;
          r_f <= 1'b0;
        end else begin
          r_a <= a;
          r_b <= b;
          r_e <= e;
          r_f <= f;
        end
      end

      assign w_ra = r_a;
      assign w_rb = r_b;
      assign w_re = r_e;
      assign w_rf = r_f;
    end else begin : g_comb_in
      assign w_ra = a;
      assign w_rb = b;
      assign w_re = e;
      assign w_rf = f;
    end
  endgenerate

  // Faulty and golden evaluation; a fault on an inner net propagates downstream.
  always_comb begin
    w_apply = inj_en & (inj_sel != SEL_NONE) & (inj_mode != 2'd0);
    w_fa    = net_op(w_ra, w_apply, inj_sel, SEL_A, inj_mode);
    w_fb    = net_op(w_rb, w_apply, inj_sel, SEL_B, inj_mode);
    w_fe    = net_op(w_re, w_apply, inj_sel, SEL_E, inj_mode);
    w_ff    = net_op(w_rf, w_apply, inj_sel, SEL_F, inj_mode);
    w_fn1   = net_op(w_fa & w_fb, w_apply, inj_sel, SEL_N1, inj_mode);
    w_fn2   = net_op(w_fe & w_ff, w_apply, inj_sel, SEL_N2, inj_mode);
    w_fy    = net_op(w_fn1 | w_fn2, w_apply, inj_sel, SEL_Y, inj_mode);
    w_gy    = (w_ra & w_rb) | (w_re & w_rf);
  end

  logic             r_y, r_y_golden, r_mismatch, r_fault_active;
  logic [CNT_W-1:0] r_cnt;

  // Register both paths, their comparison and the injection status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y            <= 1'b0;
      r_y_golden     <= 1'b0;
      r_mismatch     <= 1'b0;
      r_fault_active <= 1'b0;
    end else begin
      r_y            <= w_fy;
      r_y_golden     <= w_gy;
      r_mismatch     <= (w_fy != w_gy);
      r_fault_active <= w_apply;
    end
  end

  // Saturating count of registered mismatches; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (r_mismatch && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign y            = r_y;
  assign y_golden     = r_y_golden;
  assign mismatch     = r_mismatch;
  assign fault_active = r_fault_active;
  assign mismatch_cnt = r_cnt;

endmodule

// File: tb/tb_injection_module_sync.sv
// Bench for injection_module_sync (CNT_W=4, SYNC_IN=1): directed scenarios
// with literal expectations, then randomized traffic compared each cycle
// against a net-level reference model.
module tb_injection_module_sync;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             a = 1'b0, b = 1'b0, e = 1'b0, f = 1'b0;
  logic             inj_en = 1'b0;
  logic [2:0]       inj_sel = 3'd7;
  logic [1:0]       inj_mode = 2'd0;
  logic             cnt_clr = 1'b0;
  logic             y, y_golden, mismatch, fault_active;
  logic [CNT_W-1:0] mismatch_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  injection_module_sync #(.CNT_W(CNT_W), .SYNC_IN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .e(e), .f(f),
    .inj_en(inj_en), .inj_sel(inj_sel), .inj_mode(inj_mode), .cnt_clr(cnt_clr),
    .y(y), .y_golden(y_golden), .mismatch(mismatch), .fault_active(fault_active),
    .mismatch_cnt(mismatch_cnt)
  );

  always #5 clk = ~clk;

  // Evaluates the function as a list of 7 nets, forcing the selected one.
  function automatic logic model_eval(input logic [3:0] abef, input logic en,
                                      input logic [2:0] sel, input logic [1:0] mode);
    logic v [0:6];
    logic act;
    act = en && (sel != 3'd7) && (mode != 2'd0);
    for (int i = 0; i < 7; i++) begin
      if (i == 4)      v[i] = v[0] & v[1];
      else if (i == 5) v[i] = v[2] & v[3];
      else if (i == 6) v[i] = v[4] | v[5];
      else             v[i] = abef[3 - i];
      if (act && (int'(sel) == i)) begin
        if (mode == 2'd1)      v[i] = 1'b0;
        else if (mode == 2'd2) v[i] = 1'b1;
        else                   v[i] = ~v[i];
      end
    end
    return v[6];
  endfunction

  // Reference model state.
  logic [3:0] m_in = 4'b0;
  logic       m_y = 1'b0, m_g = 1'b0, m_mm = 1'b0, m_fa = 1'b0;
  int         m_cnt = 0;
  bit         cmp_en = 1'b0;

  // Model: inputs take one clock to enter, results one more to appear.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_in = 4'b0; m_y = 1'b0; m_g = 1'b0; m_mm = 1'b0; m_fa = 1'b0; m_cnt = 0;
    end else begin
      if (cnt_clr)                            m_cnt = 0;
      else if (m_mm && m_cnt < (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
      m_y  = model_eval(m_in, inj_en, inj_sel, inj_mode);
      m_g  = model_eval(m_in, 1'b0, 3'd7, 2'd0);
      m_mm = (m_y != m_g);
      m_fa = inj_en && (inj_sel != 3'd7) && (inj_mode != 2'd0);
      m_in = {a, b, e, f};
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_y", int'(y), int'(m_y));
      check("model_y_golden", int'(y_golden), int'(m_g));
      check("model_mismatch", int'(mismatch), int'(m_mm));
      check("model_fault_active", int'(fault_active), int'(m_fa));
      check("model_cnt", int'(mismatch_cnt), m_cnt);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] abef, input logic en,
                       input logic [2:0] sel, input logic [1:0] mode);
    {a, b, e, f} = abef;
    inj_en = en; inj_sel = sel; inj_mode = mode;
  endtask

  logic [3:0] tt_in  [6] = '{4'b0000, 4'b1000, 4'b1001, 4'b0011, 4'b1100, 4'b1111};
  logic       tt_exp [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    // Reset held with all inputs high.
    drive(4'b1111, 1'b0, 3'd7, 2'd0);
    cmp_en = 1'b1;
    step(3);
    check("rst_y", int'(y), 0);
    check("rst_y_golden", int'(y_golden), 0);
    check("rst_cnt", int'(mismatch_cnt), 0);
    rst_n = 1'b1;
    step(2);
    check("post_rst_y", int'(y), 1);

    // Truth table without injection.
    for (int i = 0; i < 6; i++) begin
      drive(tt_in[i], 1'b0, 3'd0, 2'd3);
      step(2);
      check("tt_y", int'(y), int'(tt_exp[i]));
      check("tt_y_golden", int'(y_golden), int'(tt_exp[i]));
      check("tt_mismatch", int'(mismatch), 0);
    end

    // Stuck-at-0 on n2 with e=f=1, a=0; clear counter at the same time.
    drive(4'b0011, 1'b1, 3'd5, 2'd1);
    cnt_clr = 1'b1;
    step(1);
    cnt_clr = 1'b0;
    step(1);
    check("sa0n2_y", int'(y), 0);
    check("sa0n2_y_golden", int'(y_golden), 1);
    check("sa0n2_mismatch", int'(mismatch), 1);
    check("sa0n2_fault_active", int'(fault_active), 1);
    check("sa0n2_cnt0", int'(mismatch_cnt), 0);
    step(1);
    check("sa0n2_cnt1", int'(mismatch_cnt), 1);
    step(1);
    check("sa0n2_cnt2", int'(mismatch_cnt), 2);

    // Bit-flip on y.
    drive(4'b0000, 1'b1, 3'd6, 2'd3);
    step(2);
    check("flipy_y_0000", int'(y), 1);
    check("flipy_golden_0000", int'(y_golden), 0);
    drive(4'b1100, 1'b1, 3'd6, 2'd3);
    step(2);
    check("flipy_y_1100", int'(y), 0);
    check("flipy_golden_1100", int'(y_golden), 1);

    // Stuck-at-1 on b, then masked by a=0.
    drive(4'b1000, 1'b1, 3'd1, 2'd2);
    step(2);
    check("sa1b_y", int'(y), 1);
    check("sa1b_mismatch", int'(mismatch), 1);
    drive(4'b0000, 1'b1, 3'd1, 2'd2);
    step(2);
    check("sa1b_masked_y", int'(y), 0);
    check("sa1b_masked_mismatch", int'(mismatch), 0);

    // No fault when target is 7.
    drive(4'b1111, 1'b1, 3'd7, 2'd3);
    step(2);
    check("sel7_fault_active", int'(fault_active), 0);
    check("sel7_mismatch", int'(mismatch), 0);

    // Saturation and clear priority.
    drive(4'b1000, 1'b1, 3'd1, 2'd2);
    cnt_clr = 1'b1;
    step(1);
    cnt_clr = 1'b0;
    step(20);
    check("sat_cnt", int'(mismatch_cnt), 15);
    cnt_clr = 1'b1;
    step(1);
    check("clr_cnt", int'(mismatch_cnt), 0);
    cnt_clr = 1'b0;
    step(1);
    check("resume_cnt", int'(mismatch_cnt), 1);

    // Randomized traffic with an asynchronous reset pulse mid-run.
    for (int i = 0; i < 600; i++) begin
      drive(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
            3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
      cnt_clr = ($urandom_range(0, 15) == 0);
      if (i == 300) begin
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_y", int'(y), 0);
        check("async_rst_cnt", int'(mismatch_cnt), 0);
        step(1);
        rst_n = 1'b1;
      end else begin
        step(1);
      end
    end

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
